// File: rtl/counter_pkg.sv
// Shared definitions for the synchronous up/down counter: mode constants,
// the width limit, and the width-safe next-value function.
package counter_pkg;

  localparam int CNT_MAX_W = 16;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  // One bit wider than the widest counter, so MODULUS = 2**WIDTH is representable.
  typedef logic [CNT_MAX_W:0] cnt_ext_t;

  typedef struct packed {
    cnt_ext_t nxt;
    logic     wrap;
  } cnt_step_t;

  function automatic cnt_step_t cnt_next(cnt_ext_t q, logic up, logic en,
                                         cnt_ext_t modulus, logic sat);
    cnt_step_t r;
    r.nxt  = q;
    r.wrap = 1'b0;
    if (en) begin
      if (up) begin
        if (q + 17'd1 < modulus) begin
          r.nxt = q + 17'd1;
        end else if (sat == CNT_WRAP) begin
          r.nxt  = '0;
          r.wrap = 1'b1;
        end
      end else begin
        if (q != '0) begin
          r.nxt = q - 17'd1;
        end else if (sat == CNT_WRAP) begin
          r.nxt  = modulus - 17'd1;
          r.wrap = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_next_state.sv
// Combinational next-count and wrap-flag generator; holds Q when En is low.
module counter_next_state
  import counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             en,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap
);

  localparam cnt_ext_t MOD_X = cnt_ext_t'(MODULUS);

  cnt_step_t step;
  logic      unused_hi;

  always_comb begin
    step   = cnt_next(cnt_ext_t'(q), up, en, MOD_X, SATURATE == CNT_SAT);
    q_next = step.nxt[WIDTH-1:0];
    wrap   = step.wrap;
  end

  // Upper bits are always zero because the result stays below MODULUS.
  assign unused_hi = ^step.nxt[CNT_MAX_W:WIDTH];

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with load, saturate/wrap mode,
// combinational terminal count for cascading, and a registered wrap pulse.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap
);

  if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("sync_updown_counter: WIDTH must be within 1..%0d", CNT_MAX_W);
  end
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS must be within 2..2**WIDTH");
  end
  if (SATURATE != int'(CNT_WRAP) && SATURATE != int'(CNT_SAT)) begin : g_bad_mode
    $error("sync_updown_counter: SATURATE must be 0 or 1");
  end

  localparam cnt_ext_t         MOD_X = cnt_ext_t'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic [WIDTH-1:0] load_q;

  counter_next_state #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .q     (Q),
    .up    (Up),
    .en    (En),
    .q_next(q_next),
    .wrap  (wrap_next)
  );

  // Out-of-range load values clamp to the top of the count range.
  always_comb begin
    load_q = (cnt_ext_t'(LoadVal) < MOD_X) ? LoadVal : LAST;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q    <= '0;
      Wrap <= 1'b0;
    end else if (Load) begin
      Q    <= load_q;
      Wrap <= 1'b0;
    end else begin
      Q    <= q_next;
      Wrap <= wrap_next;
    end
  end

  assign TC = En & (Up ? (Q == LAST) : (Q == '0));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: four parameterisations driven in lockstep plus a
// two-stage decade cascade, compared against an arithmetic reference model.
module tb_sync_updown_counter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst, ld, en, up, cen;
  logic [3:0] lv;

  logic [2:0] q0, q2, q3;
  logic [3:0] q1, qlo, qhi;
  logic [3:0] tcv, wv;
  logic       tclo, tchi, wlo, whi;

  sync_updown_counter #(.WIDTH(3)) d0 (
    .Clk(Clk), .Reset(rst), .En(en), .Up(up), .Load(ld), .LoadVal(lv[2:0]),
    .Q(q0), .TC(tcv[0]), .Wrap(wv[0]));
  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) d1 (
    .Clk(Clk), .Reset(rst), .En(en), .Up(up), .Load(ld), .LoadVal(lv),
    .Q(q1), .TC(tcv[1]), .Wrap(wv[1]));
  sync_updown_counter #(.WIDTH(3), .SATURATE(1)) d2 (
    .Clk(Clk), .Reset(rst), .En(en), .Up(up), .Load(ld), .LoadVal(lv[2:0]),
    .Q(q2), .TC(tcv[2]), .Wrap(wv[2]));
  sync_updown_counter #(.WIDTH(3), .MODULUS(6)) d3 (
    .Clk(Clk), .Reset(rst), .En(en), .Up(up), .Load(ld), .LoadVal(lv[2:0]),
    .Q(q3), .TC(tcv[3]), .Wrap(wv[3]));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) clo (
    .Clk(Clk), .Reset(rst), .En(cen), .Up(1'b1), .Load(1'b0), .LoadVal(4'd0),
    .Q(qlo), .TC(tclo), .Wrap(wlo));
  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) chi (
    .Clk(Clk), .Reset(rst), .En(tclo), .Up(1'b1), .Load(1'b0), .LoadVal(4'd0),
    .Q(qhi), .TC(tchi), .Wrap(whi));

  logic [3:0] qv [4];
  assign qv[0] = {1'b0, q0};
  assign qv[1] = q1;
  assign qv[2] = {1'b0, q2};
  assign qv[3] = {1'b0, q3};

  int mods [4] = '{8, 10, 8, 6};
  int sats [4] = '{0, 0, 1, 0};
  int wid  [4] = '{3, 4, 3, 3};
  int mq   [4];
  int mw   [4];
  int c, cw;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [3:0] v, input logic ce);
    int ldv, nxt;
    rst = r; ld = l; en = e; up = u; lv = v; cen = ce;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ldv = int'(v) % (1 << wid[i]);
      if (r) begin
        mq[i] = 0; mw[i] = 0;
      end else if (l) begin
        mq[i] = (ldv < mods[i]) ? ldv : mods[i] - 1;
        mw[i] = 0;
      end else if (e) begin
        nxt = u ? mq[i] + 1 : mq[i] - 1;
        if (nxt < 0 || nxt >= mods[i]) begin
          if (sats[i] != 0) begin
            mw[i] = 0;
          end else begin
            mq[i] = (nxt + mods[i]) % mods[i];
            mw[i] = 1;
          end
        end else begin
          mq[i] = nxt; mw[i] = 0;
        end
      end else begin
        mw[i] = 0;
      end
    end
    if (r) begin
      c = 0; cw = 0;
    end else if (ce) begin
      cw = (c == 99) ? 1 : 0;
      c  = (c + 1) % 100;
    end else begin
      cw = 0;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q%0d", i), 32'(qv[i]), 32'(mq[i]));
      chk($sformatf("wrap%0d", i), 32'(wv[i]), 32'(mw[i]));
      chk($sformatf("tc%0d", i), 32'(tcv[i]),
          32'(e && (u ? (mq[i] == mods[i] - 1) : (mq[i] == 0))));
    end
    chk("cas_lo", 32'(qlo), 32'(c % 10));
    chk("cas_hi", 32'(qhi), 32'(c / 10));
    chk("cas_wrap", 32'(whi), 32'(cw));
    chk("cas_tclo", 32'(tclo), 32'(ce && (c % 10 == 9)));
  endtask

  int exp_up [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};

  initial begin
    // Reset with En=1, Up=0: TC must equal En & ~Up.
    step(1, 0, 1, 0, 4'd0, 0);
    chk("rst_tc", 32'(tcv[0]), 32'd1);
    step(1, 0, 0, 1, 4'd0, 0);
    chk("rst_q", 32'(q0), 32'd0);

    // Default counter counts up 1..7,0,1,2 with one wrap pulse at Q=0.
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 1, 4'd0, 1);
      chk("plan_up", 32'(q0), 32'(exp_up[k]));
      chk("plan_wrap", 32'(wv[0]), 32'(k == 7));
    end

    // Decade counter counting down from 0.
    step(1, 0, 0, 0, 4'd0, 1);
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 1, 0, 4'd0, 1);
      chk("plan_dec", 32'(q1), 32'((9 - k + 10) % 10));
    end

    // Saturation: up 12 then down 9.
    step(1, 0, 0, 1, 4'd0, 1);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 1, 4'd0, 1);
    chk("plan_sat_hi", 32'(q2), 32'd7);
    for (int k = 0; k < 9; k++) step(0, 0, 1, 0, 4'd0, 1);
    chk("plan_sat_lo", 32'(q2), 32'd0);

    // Load overrides En, then clamped load on MODULUS=6.
    step(0, 1, 1, 1, 4'd5, 1);
    chk("plan_load", 32'(q0), 32'd5);
    step(0, 1, 0, 1, 4'd7, 1);
    chk("plan_clamp", 32'(q3), 32'd5);

    // Reset beats Load and En at Q=4, then counting resumes from 0.
    step(1, 0, 0, 1, 4'd0, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 1, 4'd0, 1);
    chk("plan_at4", 32'(q0), 32'd4);
    step(1, 1, 1, 1, 4'd5, 1);
    chk("plan_rst_ovr", 32'(q0), 32'd0);
    step(0, 0, 1, 1, 4'd0, 1);
    chk("plan_resume", 32'(q0), 32'd1);

    // Cascade runs through 00..99 and wraps.
    step(1, 0, 0, 1, 4'd0, 0);
    for (int k = 0; k < 205; k++) step(0, 0, 1, 1, 4'd0, 1);
    chk("plan_cascade", 32'(qhi * 10 + qlo), 32'(205 % 100));

    // Randomised traffic on every control input.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
